uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter among `N_REQ` byte producers, e.g. an echo path fed by the UART receiver, a status reporter and a debug dumper. It accepts one byte per valid/ready handshake, latches it, and issues a one-cycle start to the transmitter. It then tracks the transmitter's `busy` through a full frame before granting the next requester. It sits between the producers and the UART transmitter, in the same clock domain.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be at least 2.
- `FRAME_DATA_LENGTH`, 8: byte width; must match the transmitter.
- `START_TIMEOUT`, 1024: `clk` cycles to wait for `tx_busy` to rise after `tx_start` before flagging an error.

Ports:
- `clk`  in  1  system clock; all logic on posedge. Clock is single; reset is synchronous, active-high.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  N_REQ  bit i set: requester i has a byte.
- `req_data`  in  N_REQ*FRAME_DATA_LENGTH  requester i's byte is slice [i*W +: W].
- `req_ready`  out  N_REQ  one-hot pulse: byte of requester i accepted this cycle.
- `tx_start`  out  1  one-cycle start strobe to the transmitter.
- `tx_data`  out  FRAME_DATA_LENGTH  held stable from the `tx_start` cycle until the frame ends.
- `tx_busy`  in  1  transmitter busy.
- `grant_id`  out  $clog2(N_REQ)  index of the current or last granted requester.
- `active`  out  1  high in every state except IDLE.
- `start_error`  out  1  sticky; set on timeout; cleared only by `reset`.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE, with `tx_busy`=0 and some `req_valid` set:
  - select the first set bit searching from `(last_grant+1) mod N_REQ`, wrapping;
  - pulse `req_ready[sel]`, latch `req_data[sel]` into `tx_data`, set `grant_id`=sel;
  - go to LAUNCH.
- IDLE with `tx_busy`=1 (e.g. transmitter still finishing after a reset): grant nothing.
- LAUNCH: `tx_start`=1 for exactly this cycle, then WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - `tx_busy`=1 → WAIT_DONE;
  - counter reaches `START_TIMEOUT-1` → set `start_error`, go to IDLE.
- WAIT_DONE: `tx_busy`=0 → IDLE, and `last_grant` ← `grant_id`.
- The round-robin pointer updates only on a completed frame or a timeout. It never updates on a grant alone.
- The handshake is valid/ready. A requester holds `req_valid` and its data until it sees `req_ready`. Deasserting `req_valid` before the grant is legal; that requester is simply skipped.
- `req_ready` is never asserted for a requester whose `req_valid` is low in the same cycle.
- Timeout counter width: $clog2(START_TIMEOUT+1); it saturates and does not wrap.

## Timing
- Reset values: state IDLE, `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `active`=0, `start_error`=0. `last_grant`=N_REQ-1, so requester 0 has first priority.
- Latency: `req_valid` high in IDLE → `req_ready` in the same cycle. `tx_start` follows one cycle later.
- Minimum spacing between grants is the frame time plus 3 cycles (LAUNCH, the first WAIT_BUSY cycle, and the IDLE re-arbitration cycle).
- `tx_busy` may rise any number of cycles after `tx_start`, up to the timeout; the transmitter's divider may delay its start.
- `tx_busy` already high in the first WAIT_BUSY cycle is accepted as the start of the frame.
- All requesters valid continuously → grants cycle 0,1,2,3,0,…
- `reset` asserted in any state:
  - next cycle is IDLE with reset values;
  - the latched byte is dropped; its `req_ready` already fired, so the producer does not resend;
  - any in-flight frame finishes on its own, and the IDLE `tx_busy` guard blocks new grants until it does.

## Structure
- Shared package `uart_pkg` holds the state encoding constants (IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3) and the default `FRAME_DATA_LENGTH`.
- One sub-module, `rr_pick`: purely combinational. Inputs are the request vector and the last grant. Outputs are the one-hot grant, its index and an any-request flag. The FSM stays in `uart_tx_arbiter`.

## Test plan
- Single request: `req_valid`=4'b0100 with data 8'hA5; transmitter model raises busy 3 cycles after start for 20 cycles → `req_ready`=4'b0100 once, `tx_start` one cycle later, `tx_data`=8'hA5 stable throughout, `grant_id`=2, `active` drops after busy falls.
- Fairness: all four requesters valid for 8 frames → grant order 0,1,2,3,0,1,2,3 with one `req_ready` per frame.
- Skip and wrap: after a grant to 3, only requester 1 valid → next grant 1; then 0 and 2 valid → next grant 2.
- Timeout: `START_TIMEOUT`=16 and busy never rises → `start_error`=1 sixteen cycles after WAIT_BUSY entry, return to IDLE; the next request is still served and `start_error` stays 1.
- Busy blocking: `tx_busy` held high from reset while 0 is valid → no `req_ready` until busy falls, then grant 0.
- Mid-frame reset: `reset` pulsed during WAIT_DONE while busy is high → all outputs at reset values; no grant until busy falls, then next grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame defaults for the UART TX arbiter
package uart_pkg;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   localparam int DEFAULT_FRAME_DATA_LENGTH = 8;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the last grant
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_grant,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     any_req
);
   localparam int IW = $clog2(N_REQ);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      // Search order wraps from last_grant+1 back around to last_grant itself.
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant) + k) % N_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx[IW-1:0];
         end
      end
   end

   assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among byte producers
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ             = 4,
   parameter int FRAME_DATA_LENGTH = DEFAULT_FRAME_DATA_LENGTH,
   parameter int START_TIMEOUT     = 1024
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N_REQ-1:0]                   req_valid,
   input  logic [N_REQ*FRAME_DATA_LENGTH-1:0] req_data,
   output logic [N_REQ-1:0]                   req_ready,
   output logic                               tx_start,
   output logic [FRAME_DATA_LENGTH-1:0]       tx_data,
   input  logic                               tx_busy,
   output logic [$clog2(N_REQ)-1:0]           grant_id,
   output logic                               active,
   output logic                               start_error
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMER_LAST = CW'(START_TIMEOUT - 1);

   state_t          state;
   logic [IW-1:0]   last_grant;
   logic [CW-1:0]   timer;
   logic [N_REQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic            do_grant;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .grant_idx  (pick_idx),
      .any_req    (pick_any)
   );

   // Ready is combinational so the producer sees acceptance in the cycle it offers;
   // gating with reset keeps a byte from being swallowed while the FSM is held.
   assign do_grant  = !reset && (state == IDLE) && !tx_busy && pick_any;
   assign req_ready = do_grant ? pick_grant : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         active      <= 1'b0;
         start_error <= 1'b0;
         last_grant  <= IW'(N_REQ - 1);
         timer       <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (do_grant) begin
                  tx_data  <= req_data[int'(pick_idx)*FRAME_DATA_LENGTH +: FRAME_DATA_LENGTH];
                  grant_id <= pick_idx;
                  tx_start <= 1'b1;
                  active   <= 1'b1;
                  state    <= LAUNCH;
               end
            end
            LAUNCH: begin
               timer <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (timer == TIMER_LAST) begin
                  start_error <= 1'b1;
                  last_grant  <= grant_id;
                  active      <= 1'b0;
                  state       <= IDLE;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  last_grant <= grant_id;
                  active     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        start_error;

   logic        model_busy = 1'b0;
   logic        model_run = 1'b0;
   logic        force_busy = 1'b0;
   logic        tx_en = 1'b1;
   int          tx_delay = 3;
   int          tx_len = 20;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ready_count = 0;
   int          bad_busy = 0;
   int          last_ready_cyc = -10;
   logic [3:0]  last_ready_vec = '0;
   logic [3:0]  rdy_seen = '0;
   logic [7:0]  cur_data = '0;
   int          start_cyc = 0;
   int          busy_fall_cyc = 0;
   int          active_fall_cyc = 0;
   logic        prev_busy = 1'b0;
   logic        prev_active = 1'b0;

   logic [7:0]  src_q [4][$];
   logic [9:0]  exp_q [$];

   assign tx_busy = model_busy | force_busy;

   uart_tx_arbiter #(
      .N_REQ(4), .FRAME_DATA_LENGTH(8), .START_TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
      .start_error(start_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Producers: hold valid/data until accepted, then advance to the next queued byte.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (rdy_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[i*8 +: 8] = src_q[i][0];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
         end
      end
      rdy_seen = '0;
   end

   // Transmitter model: busy rises tx_delay cycles after start and lasts tx_len cycles.
   always begin
      @(negedge clk);
      if (tx_start && tx_en) begin
         model_run = 1'b1;
         repeat (tx_delay) @(posedge clk);
         #1 model_busy = 1'b1;
         repeat (tx_len) @(posedge clk);
         #1 model_busy = 1'b0;
         model_run = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (|req_ready) begin
         checks++;
         if (!$onehot(req_ready) || (req_ready & ~req_valid) != 4'b0) begin
            errors++;
            $display("FAIL ready_shape ready=%b valid=%b", req_ready, req_valid);
         end
         if (tx_busy) bad_busy++;
         ready_count++;
         last_ready_cyc = cyc;
         last_ready_vec = req_ready;
         rdy_seen       = req_ready;
      end
      if (tx_start) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_start grant=%0d data=%h", grant_id, tx_data);
         end else begin
            e = exp_q.pop_front();
            if ({grant_id, tx_data} !== e) begin
               errors++;
               $display("FAIL grant_data got id=%0d data=%h want id=%0d data=%h",
                        grant_id, tx_data, e[9:8], e[7:0]);
            end
            checks++;
            if (cyc !== last_ready_cyc + 1 || last_ready_vec !== (4'b0001 << grant_id)) begin
               errors++;
               $display("FAIL start_latency start_cyc=%0d ready_cyc=%0d ready=%b grant=%0d",
                        cyc, last_ready_cyc, last_ready_vec, grant_id);
            end
         end
         cur_data  = tx_data;
         start_cyc = cyc;
      end else if (active) begin
         checks++;
         if (tx_data !== cur_data) begin
            errors++;
            $display("FAIL tx_data_stable got %h want %h", tx_data, cur_data);
         end
      end
      if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
      if (prev_active && !active) active_fall_cyc = cyc;
      prev_busy   = tx_busy;
      prev_active = active;
   end

   function automatic bit src_empty();
      for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (n < 3000 && !(exp_q.size() == 0 && src_empty() && !active && !tx_busy && !model_run)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s idle_timeout expected_left=%0d", name, exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
      checks++; if (start_error !== 1'b0) begin errors++; $display("FAIL reset_start_error got %b want 0", start_error); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      int rc0;
      rc0 = ready_count;
      @(negedge clk);
      src_q[2].push_back(8'hA5);
      exp_q.push_back({2'd2, 8'hA5});
      wait_idle("single");
      checks++;
      if (ready_count - rc0 !== 1) begin
         errors++; $display("FAIL single_ready_count got %0d want 1", ready_count - rc0);
      end
      checks++;
      if (active_fall_cyc !== busy_fall_cyc + 1) begin
         errors++; $display("FAIL single_active_drop got cyc %0d want %0d", active_fall_cyc, busy_fall_cyc + 1);
      end
   endtask

   task automatic test_fairness();
      int rc0;
      pulse_reset();
      rc0 = ready_count;
      for (int i = 0; i < 4; i++) begin
         src_q[i].push_back(8'(i * 16));
         src_q[i].push_back(8'(i * 16 + 1));
      end
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 8'(i * 16 + f)});
      wait_idle("fairness");
      checks++;
      if (ready_count - rc0 !== 8) begin
         errors++; $display("FAIL fairness_ready_count got %0d want 8", ready_count - rc0);
      end
   endtask

   task automatic test_skip_wrap();
      src_q[1].push_back(8'h11);
      exp_q.push_back({2'd1, 8'h11});
      wait_idle("skip");
      src_q[0].push_back(8'h20);
      src_q[2].push_back(8'h22);
      exp_q.push_back({2'd2, 8'h22});
      exp_q.push_back({2'd0, 8'h20});
      wait_idle("wrap");
   endtask

   task automatic test_timeout();
      int n;
      tx_en = 1'b0;
      src_q[3].push_back(8'h33);
      exp_q.push_back({2'd3, 8'h33});
      n = 0;
      while (n < 200 && !start_error) begin @(negedge clk); n++; end
      checks++;
      if (cyc !== start_cyc + 17) begin
         errors++; $display("FAIL timeout_cycle got %0d want %0d", cyc, start_cyc + 17);
      end
      checks++;
      if (active !== 1'b0) begin errors++; $display("FAIL timeout_idle active=%b want 0", active); end
      tx_en = 1'b1;
      src_q[1].push_back(8'h44);
      exp_q.push_back({2'd1, 8'h44});
      wait_idle("after_timeout");
      checks++;
      if (start_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", start_error); end
   endtask

   task automatic test_busy_block();
      int rc0;
      force_busy = 1'b1;
      pulse_reset();
      checks++;
      if (start_error !== 1'b0) begin errors++; $display("FAIL busy_reset_error got %b want 0", start_error); end
      rc0 = ready_count;
      src_q[0].push_back(8'h55);
      exp_q.push_back({2'd0, 8'h55});
      repeat (10) @(negedge clk);
      checks++;
      if (ready_count !== rc0 || src_q[0].size() !== 1) begin
         errors++; $display("FAIL busy_block ready_delta=%0d pending=%0d want 0 and 1", ready_count - rc0, src_q[0].size());
      end
      force_busy = 1'b0;
      wait_idle("busy_block");
   endtask

   task automatic test_midframe_reset();
      int n;
      src_q[1].push_back(8'h66);
      exp_q.push_back({2'd1, 8'h66});
      n = 0;
      while (n < 200 && !(active && tx_busy)) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({req_ready, tx_start, tx_data, grant_id, active, start_error} !== 17'd0 || tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset_values ready=%b start=%b data=%h id=%0d active=%b err=%b busy=%b want zeros busy=1",
                  req_ready, tx_start, tx_data, grant_id, active, start_error, tx_busy);
      end
      src_q[2].push_back(8'h77);
      src_q[0].push_back(8'h70);
      exp_q.push_back({2'd0, 8'h70});
      exp_q.push_back({2'd2, 8'h77});
      wait_idle("midreset");
      checks++;
      if (bad_busy !== 0) begin errors++; $display("FAIL ready_while_busy got %0d want 0", bad_busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_skip_wrap();
      test_timeout();
      test_busy_block();
      test_midframe_reset();
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "simulation time limit");
   end
endmodule
